fixed_point_multiplier: RTL and testbench

//   Signed two's-complement fixed-point multiplier for the fixed-point datapath.

---
 rtl/fixed_point_multiplier.sv | 93 +++++++++
 tb/tb_fixed_point_multiplier.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/fixed_point_multiplier.sv
// Signed fixed-point multiplier: Q(WI1.WF1) x Q(WI2.WF2) -> Q(WIO.WFO).
// Floor truncation / zero padding on the fraction, saturation on the integer part, one register stage.
module fixed_point_multiplier #(
    parameter int WI1 = 4,
    parameter int WI2 = 3,
    parameter int WF1 = 5,
    parameter int WF2 = 3,
    parameter int WIO = WI1 + WI2,
    parameter int WFO = WF1 + WF2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [WI1+WF1-1:0]     data_in1,
    input  logic [WI2+WF2-1:0]     data_in2,
    output logic                   out_valid,
    output logic [WIO+WFO-1:0]     data_out,
    output logic                   overflow
);

    localparam int PW = WI1 + WI2 + WF1 + WF2;
    localparam int PF = WF1 + WF2;
    localparam int AW = WI1 + WI2 + WFO;
    localparam int OW = WIO + WFO;

    logic signed [PW-1:0] prod_p0;
    logic signed [AW-1:0] aligned_p0;
    logic signed [OW-1:0] res_p0;
    logic                 ovf_p0;

    logic signed [OW-1:0] data_p1;
    logic                 ovf_p1;
    logic                 vld_p1;

    // ---- stage p0: exact product, fraction and integer alignment ----
    assign prod_p0 = PW'($signed(data_in1)) * PW'($signed(data_in2));

    generate
        if (WFO < PF) begin : g_trunc
            function automatic logic signed [AW-1:0] trunc_floor(input logic signed [PW-1:0] p);
                logic signed [PW-1:0] s;
                s = p >>> (PF - WFO);
                return s[AW-1:0];
            endfunction
            assign aligned_p0 = trunc_floor(prod_p0);
        end else begin : g_pad
            function automatic logic signed [AW-1:0] pad_zero(input logic signed [PW-1:0] p);
                logic signed [AW-1:0] w;
                w = AW'(p);
                return w <<< (WFO - PF);
            endfunction
            assign aligned_p0 = pad_zero(prod_p0);
        end
    endgenerate

    generate
        if (OW < AW) begin : g_sat
            // Fits when every bit from the MSB down to the output sign position agrees.
            function automatic logic [OW:0] saturate(input logic signed [AW-1:0] v);
                if (v[AW-1:OW-1] == {(AW-OW+1){v[AW-1]}})
                    return {1'b0, v[OW-1:0]};
                else if (v[AW-1])
                    return {1'b1, 1'b1, {(OW-1){1'b0}}};
                else
                    return {1'b1, 1'b0, {(OW-1){1'b1}}};
            endfunction
            assign {ovf_p0, res_p0} = saturate(aligned_p0);
        end else begin : g_ext
            assign res_p0 = OW'(aligned_p0);
            assign ovf_p0 = 1'b0;
        end
    endgenerate

    // ---- stage p1: output register; data and flag hold when no new operands ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            ovf_p1  <= 1'b0;
        end else begin
            vld_p1 <= in_valid;
            if (in_valid) begin
                data_p1 <= res_p0;
                ovf_p1  <= ovf_p0;
            end
        end
    end

    assign out_valid = vld_p1;
    assign data_out  = data_p1;
    assign overflow  = ovf_p1;

endmodule

// File: tb/tb_fixed_point_multiplier.sv
// Directed bench: default (lossless) instance plus a Q4.4-output instance for truncation and saturation.
module tb_fixed_point_multiplier;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [8:0]  data_in1 = '0;
    logic [5:0]  data_in2 = '0;

    logic        out_valid;
    logic [14:0] data_out;
    logic        overflow;
    logic        out_valid_s;
    logic [7:0]  data_out_s;
    logic        overflow_s;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    fixed_point_multiplier dut (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .data_in1(data_in1), .data_in2(data_in2),
        .out_valid(out_valid), .data_out(data_out), .overflow(overflow)
    );

    fixed_point_multiplier #(.WIO(4), .WFO(4)) dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .data_in1(data_in1), .data_in2(data_in2),
        .out_valid(out_valid_s), .data_out(data_out_s), .overflow(overflow_s)
    );

    // Present one operand pair, let one rising edge capture it, settle 1 ns past the edge.
    task automatic drive(input logic [8:0] a, input logic [5:0] b, input logic v);
        data_in1 = a;
        data_in2 = b;
        in_valid = v;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        total++;
        if (data_out !== 15'h0 || out_valid !== 1'b0 || overflow !== 1'b0)
            $display("FAIL reset_main: got data=%h vld=%b ovf=%b, want 0 0 0", data_out, out_valid, overflow);
        else passed++;
        total++;
        if (data_out_s !== 8'h0 || out_valid_s !== 1'b0 || overflow_s !== 1'b0)
            $display("FAIL reset_sat: got data=%h vld=%b ovf=%b, want 0 0 0", data_out_s, out_valid_s, overflow_s);
        else passed++;
        rst = 1'b0;
    endtask

    task automatic test_nominal();
        drive(9'b0100_10101, 6'b011_101, 1'b1);
        total++;
        if (data_out !== 15'h10E1) $display("FAIL nominal_data: got %h want 10e1", data_out);
        else passed++;
        total++;
        if (out_valid !== 1'b1 || overflow !== 1'b0)
            $display("FAIL nominal_flags: got vld=%b ovf=%b want 1 0", out_valid, overflow);
        else passed++;
    endtask

    task automatic test_mixed_sign();
        drive(9'b1111_00000, 6'b010_000, 1'b1);
        total++;
        if (data_out !== 15'h7E00 || overflow !== 1'b0)
            $display("FAIL mixed_sign: got %h ovf=%b want 7e00 0", data_out, overflow);
        else passed++;
    endtask

    task automatic test_extremes();
        drive(9'b1000_00000, 6'b100_000, 1'b1);
        total++;
        if (data_out !== 15'h2000 || overflow !== 1'b0)
            $display("FAIL extremes: got %h ovf=%b want 2000 0", data_out, overflow);
        else passed++;
    endtask

    task automatic test_hold();
        for (int i = 0; i < 3; i++) begin
            drive(9'h1FF, 6'h3F, 1'b0);
            total++;
            if (out_valid !== 1'b0 || data_out !== 15'h2000)
                $display("FAIL hold_%0d: got vld=%b data=%h want 0 2000", i, out_valid, data_out);
            else passed++;
        end
    endtask

    task automatic test_saturation();
        logic [8:0] a [5] = '{9'd149, 9'd16, 9'd1, 9'h100, 9'd32};
        logic [5:0] b [5] = '{6'd29, 6'b111_101, 6'b111_101, 6'd29, 6'd12};
        logic [7:0] ed[5] = '{8'h7F, 8'hFD, 8'hFF, 8'h80, 8'h18};
        logic       eo[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            drive(a[i], b[i], 1'b1);
            total++;
            if (data_out_s !== ed[i] || overflow_s !== eo[i] || out_valid_s !== 1'b1)
                $display("FAIL sat_%0d: got data=%h ovf=%b vld=%b want %h %b 1",
                         i, data_out_s, overflow_s, out_valid_s, ed[i], eo[i]);
            else passed++;
        end
        // Saturated result and its flag hold while idle.
        drive(9'd0, 6'd0, 1'b0);
        total++;
        if (data_out_s !== 8'h18 || overflow_s !== 1'b0 || out_valid_s !== 1'b0)
            $display("FAIL sat_hold: got data=%h ovf=%b vld=%b want 18 0 0", data_out_s, overflow_s, out_valid_s);
        else passed++;
        drive(9'h100, 6'd29, 1'b1);
        drive(9'd5, 6'd5, 1'b0);
        total++;
        if (data_out_s !== 8'h80 || overflow_s !== 1'b1 || out_valid_s !== 1'b0)
            $display("FAIL sat_ovf_hold: got data=%h ovf=%b vld=%b want 80 1 0", data_out_s, overflow_s, out_valid_s);
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic [8:0]  a [4] = '{9'b0100_10101, 9'b1111_00000, 9'b1000_00000, 9'd1};
        logic [5:0]  b [4] = '{6'b011_101, 6'b010_000, 6'b100_000, 6'd1};
        logic [14:0] e [4] = '{15'h10E1, 15'h7E00, 15'h2000, 15'h0001};
        for (int i = 0; i < 4; i++) begin
            drive(a[i], b[i], 1'b1);
            total++;
            if (data_out !== e[i] || out_valid !== 1'b1)
                $display("FAIL b2b_%0d: got data=%h vld=%b want %h 1", i, data_out, out_valid, e[i]);
            else passed++;
        end
    endtask

    task automatic test_async_reset();
        drive(9'b0100_10101, 6'b011_101, 1'b1);
        #3;
        rst = 1'b1;
        #1;
        total++;
        if (data_out !== 15'h0 || out_valid !== 1'b0 || overflow !== 1'b0)
            $display("FAIL async_reset_main: got data=%h vld=%b ovf=%b want 0 0 0", data_out, out_valid, overflow);
        else passed++;
        total++;
        if (data_out_s !== 8'h0 || out_valid_s !== 1'b0 || overflow_s !== 1'b0)
            $display("FAIL async_reset_sat: got data=%h vld=%b ovf=%b want 0 0 0", data_out_s, out_valid_s, overflow_s);
        else passed++;
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(9'b1111_00000, 6'b010_000, 1'b1);
        total++;
        if (data_out !== 15'h7E00 || out_valid !== 1'b1)
            $display("FAIL post_reset: got data=%h vld=%b want 7e00 1", data_out, out_valid);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_mixed_sign();
        test_extremes();
        test_hold();
        test_saturation();
        test_back_to_back();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
